// File: rtl/ifid_queue.sv
// IF/ID fetch queue: buffers {pc, pc+4, instr} from fetch and presents them in order to decode.
// Outputs are driven only from registered state; a flush empties the queue synchronously.
module ifid_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       if_valid_in,
  output logic                       if_ready_out,
  input  logic [WIDTH-1:0]           pc_in,
  input  logic [WIDTH-1:0]           pc_plus4_in,
  input  logic [31:0]                instr_in,
  output logic                       id_valid_out,
  input  logic                       id_ready_in,
  output logic [WIDTH-1:0]           pc_out,
  output logic [WIDTH-1:0]           pc_plus4_out,
  output logic [31:0]                instr_out,
  output logic                       stall_pc_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  logic [WIDTH-1:0] pc_q       [DEPTH];
  logic [WIDTH-1:0] pc_plus4_q [DEPTH];
  logic [31:0]      instr_q    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push, pop;
  logic not_full, not_empty;

  assign not_full  = (count_q < DepthC);
  assign not_empty = (count_q != '0);
  assign push      = if_valid_in & not_full;
  assign pop       = not_empty & id_ready_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]       <= '0;
        pc_plus4_q[i] <= '0;
        instr_q[i]    <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // A push in a flush cycle is dropped, so the slot write is suppressed too.
      if (push && !flush_in) begin
        pc_q[wr_ptr_q]       <= pc_in;
        pc_plus4_q[wr_ptr_q] <= pc_plus4_in;
        instr_q[wr_ptr_q]    <= instr_in;
      end
    end
  end

  always_comb begin
    if_ready_out = not_full;
    stall_pc_out = ~not_full;
    id_valid_out = not_empty;
    count_out    = count_q;
    pc_out       = '0;
    pc_plus4_out = '0;
    instr_out    = NopInstr;
    if (not_empty) begin
      pc_out       = pc_q[rd_ptr_q];
      pc_plus4_out = pc_plus4_q[rd_ptr_q];
      instr_out    = instr_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// Bench for ifid_queue: table of per-cycle vectors plus a queue scoreboard of accepted PCs.
module tb_ifid_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, if_valid, if_ready, id_valid, id_ready, stall;
  logic [31:0] pc_i, pc4_i, instr_i, pc_o, pc4_o, instr_o;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  ifid_queue #(.WIDTH(32), .DEPTH(2)) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .flush_in    (flush),
    .if_valid_in (if_valid),
    .if_ready_out(if_ready),
    .pc_in       (pc_i),
    .pc_plus4_in (pc4_i),
    .instr_in    (instr_i),
    .id_valid_out(id_valid),
    .id_ready_in (id_ready),
    .pc_out      (pc_o),
    .pc_plus4_out(pc4_o),
    .instr_out   (instr_o),
    .stall_pc_out(stall),
    .count_out   (count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {8'hA5, pc[23:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs against the scoreboard, update it, then advance one clock.
  task automatic apply(input logic iv, input logic [31:0] pc, input logic ir, input logic fl);
    int n;
    flush    = fl;
    if_valid = iv;
    pc_i     = pc;
    pc4_i    = pc + 32'd4;
    instr_i  = instr_of(pc);
    id_ready = ir;
    n = sb.size();
    chk("sb_valid", 32'(id_valid), 32'(n != 0));
    chk("sb_count", 32'(count), 32'(n));
    chk("sb_ready", 32'(if_ready), 32'(n < 2));
    chk("sb_stall", 32'(stall), 32'(n >= 2));
    if (n != 0) begin
      chk("sb_pc", pc_o, sb[0]);
      chk("sb_pc4", pc4_o, sb[0] + 32'd4);
      chk("sb_instr", instr_o, instr_of(sb[0]));
    end else begin
      chk("sb_pc_idle", pc_o, 32'h0);
      chk("sb_pc4_idle", pc4_o, 32'h0);
      chk("sb_nop", instr_o, 32'h0000_0013);
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (ir && n != 0) void'(sb.pop_front());
      if (iv && n < 2) sb.push_back(pc);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ir;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic [1:0]  ecnt;
  } vec_t;

  vec_t vecs[26];

  initial begin
    int n_push, n_pop;
    logic iv, ir;

    vecs = '{
      // streaming
      '{1'b1, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 2'd0},
      '{1'b1, 32'h004, 1'b1, 1'b0, 1'b1, 32'h000, 2'd1},
      '{1'b1, 32'h008, 1'b1, 1'b0, 1'b1, 32'h004, 2'd1},
      '{1'b1, 32'h00C, 1'b1, 1'b0, 1'b1, 32'h008, 2'd1},
      '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h00C, 2'd1},
      '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      // backpressure; 0x108 offered while full
      '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 32'h100, 2'd1},
      '{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 2'd2},
      '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h100, 2'd2},
      '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h104, 2'd1},
      '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      // flush while full, with push and pop requested
      '{1'b1, 32'h020, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      '{1'b1, 32'h024, 1'b0, 1'b0, 1'b1, 32'h020, 2'd1},
      '{1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h020, 2'd2},
      '{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 32'h300, 2'd1},
      '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h300, 2'd1},
      '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      // simultaneous push/pop at count 1
      '{1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 32'h000, 2'd0},
      '{1'b1, 32'h404, 1'b1, 1'b0, 1'b1, 32'h400, 2'd1},
      '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h404, 2'd1},
      '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      // flush at count 1 drops a push that would otherwise be accepted
      '{1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0},
      '{1'b1, 32'h504, 1'b1, 1'b1, 1'b1, 32'h500, 2'd1},
      '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 2'd0}
    };

    flush = 0; if_valid = 0; id_ready = 0; pc_i = 0; pc4_i = 0; instr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(id_valid), 32'h0);
    chk("reset_instr", instr_o, 32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d_ready", i), 32'(if_ready), 32'(vecs[i].ecnt != 2'd2));
      if (vecs[i].ev) chk($sformatf("v%0d_pc", i), pc_o, vecs[i].epc);
      apply(vecs[i].iv, vecs[i].pc, vecs[i].ir, vecs[i].fl);
    end

    // Wrap: 10 entries with decode ready alternating 1,0,1,0...
    n_push = 0;
    n_pop  = 0;
    for (int c = 0; c < 60 && n_pop < 10; c++) begin
      iv = (n_push < 10);
      ir = (c % 2 == 0);
      if (ir && sb.size() != 0) begin
        chk("wrap_order", pc_o, 32'h600 + 32'(4 * n_pop));
        n_pop++;
      end
      if (iv && sb.size() < 2) n_push++;
      apply(iv, 32'h600 + 32'(4 * n_push - (iv && sb.size() < 2 ? 4 : 0)), ir, 1'b0);
    end
    chk("wrap_done", 32'(n_pop), 32'd10);
    apply(1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with two entries held.
    apply(1'b1, 32'h800, 1'b0, 1'b0);
    apply(1'b1, 32'h804, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    if_valid = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc4", pc4_o, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(if_ready), 32'h1);
    chk("rst_stall", 32'(stall), 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 32'h700, 1'b0, 1'b0);
    chk("post_rst_pc", pc_o, 32'h700);
    apply(1'b0, 32'h0, 1'b1, 1'b0);
    apply(1'b0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Two-entry (parameterizable) fetch queue forming the IF/ID boundary of the RISC-V pipeline. It captures the current PC, PC+4 and the fetched instruction word from the fetch stage and presents them, in order, to the decode stage over a valid/ready handshake. It supplies a stall indication back to the PC register, and discards all buffered entries on a branch/jump redirect.

## Interface
Parameters:
- WIDTH, 32, PC width in bits.
- DEPTH, 2, queue entries; power of two, ≥2.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset; asynchronous, active-low.
- flush_in  in  1  redirect from execute; synchronously empties the queue.
- if_valid_in  in  1  fetch presents an entry this cycle.
- if_ready_out  out  1  queue can accept an entry.
- pc_in  in  WIDTH  PC of the fetched instruction.
- pc_plus4_in  in  WIDTH  PC+4 of the fetched instruction.
- instr_in  in  32  fetched instruction word.
- id_valid_out  out  1  head entry valid for decode.
- id_ready_in  in  1  decode consumes the head entry this cycle.
- pc_out  out  WIDTH  head PC.
- pc_plus4_out  out  WIDTH  head PC+4.
- instr_out  out  32  head instruction.
- stall_pc_out  out  1  hold the PC register (= ~if_ready_out).
- count_out  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: DEPTH × (WIDTH + WIDTH + 32) flop array with write pointer, read pointer and count; pointers wrap modulo DEPTH.
- Push = if_valid_in & if_ready_out. Pop = id_valid_out & id_ready_in.
- if_ready_out = (count < DEPTH). It is a function of registered count only, with no combinational path from id_ready_in.
- id_valid_out = (count != 0). There is no bypass: an entry pushed in cycle N is visible at the outputs in cycle N+1.
- When id_valid_out=1, the outputs show the head entry (read-pointer slot).
- When id_valid_out=0, pc_out=0, pc_plus4_out=0 and instr_out=32'h0000_0013 (NOP).
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Full (count=DEPTH): if_ready_out=0, so push is impossible. A pop in that cycle frees a slot that becomes usable in the next cycle.
- Empty: pop is impossible because id_valid_out=0.
- flush_in=1 takes priority over push and pop in the same cycle:
  - count, write pointer and read pointer are cleared to 0.
  - Any push or pop in that cycle is discarded.
  - Storage contents need not be cleared.
- Asynchronous reset (including mid-transfer): count=0, pointers=0, storage=0 immediately. The resulting outputs are id_valid_out=0, if_ready_out=1, stall_pc_out=0, count_out=0, pc_out=0, pc_plus4_out=0, instr_out=32'h0000_0013.
- Entries are never reordered, duplicated or dropped, except by flush or reset.

## Timing
- Latency from push to visibility: 1 cycle. Throughput: 1 entry/cycle sustained when decode is always ready.
- All outputs are driven from flops or a mux over flops. No input-to-output combinational path exists.
- if_ready_out and stall_pc_out reflect the state after the previous edge. The PC register must hold while stall_pc_out=1.
- Flush asserted in cycle N: id_valid_out=0 and if_ready_out=1 in cycle N+1. A push in cycle N+1 appears at the outputs in cycle N+2.
- Reset deassertion is expected to be synchronized externally. The first push is accepted on the first edge after deassertion.

## Test plan
- Reset: assert rst_in low mid-cycle with 2 entries held. Outputs must change immediately, without waiting for a clock edge: id_valid_out=0, instr_out=0x00000013, count_out=0, if_ready_out=1.
- Streaming: push PC 0x0, 0x4, 0x8, 0xC on consecutive cycles with id_ready_in=1. Required response:
  - Decode sees the same sequence one cycle later.
  - pc_plus4_out is 0x4, 0x8, 0xC, 0x10.
  - count_out stays at 1.
  - stall_pc_out is never asserted.
- Backpressure: hold id_ready_in=0 and push 0x100 and 0x104. Required response:
  - count_out reaches 2, if_ready_out=0, stall_pc_out=1.
  - Pushing 0x108 while full is ignored.
  - Release id_ready_in: decode sees 0x100 then 0x104, and 0x108 is absent until re-presented.
- Wrap: run 10 entries through with alternating id_ready_in (1,0,1,0…). All PCs must arrive in order with no loss or duplication, and the pointers wrap correctly.
- Flush: with 2 entries queued, assert flush_in together with if_valid_in (PC 0x200) and id_ready_in=1. Required response:
  - Next cycle: id_valid_out=0, count_out=0, 0x200 not stored.
  - Push 0x300 the following cycle: it appears one cycle later.
- Simultaneous push/pop at count=1: count stays 1 and the head advances to the newly pushed entry on the following cycle.
